// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding and defaults for the key debouncer
package key_pkg;

  // Per-key debounce FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    UP        = 2'd0,
    PEND_DOWN = 2'd1,
    DOWN      = 2'd2,
    PEND_UP   = 2'd3
  } key_fsm_e;

  localparam int KEY_NKEYS            = 4;
  localparam int KEY_DEBOUNCE_DEFAULT = 250000;
  localparam int KEY_SYNC_DEFAULT     = 2;

  // Debounced level is high in both states that follow an accepted press
  function automatic logic key_level(input key_fsm_e st);
    return (st == DOWN) || (st == PEND_UP);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchronizer, debounce FSM, event pulses (KEY_DEBOUNCE_EVENTS_EN)
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = KEY_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_raw_i,
  output logic key_state_o,
  output logic key_press_o,
  output logic key_release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_fsm_e               state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   key_state_q, key_state_d;

  // Synchronizer chain; resets to the released (high) pin level so reset release is silent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_raw_i};
    end
  end

  assign s = ~sync_q[SYNC_STAGES-1];

  // Next-state logic: any disagreeing sample during a pending phase drops back and restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UP: begin
        if (s) begin
          state_d = PEND_DOWN;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_DOWN: begin
        if (!s) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DOWN: begin
        if (!s) begin
          state_d = PEND_UP;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_UP: begin
        if (s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
    key_state_d = key_level(state_d);
  end

  // FSM state, stability counter and registered debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UP;
      cnt_q       <= '0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
    end
  end

  assign key_state_o = key_state_q;

`ifdef KEY_DEBOUNCE_EVENTS_EN
  logic press_q, release_q;

  // Edge detect on the level about to be registered, so the pulse lines up with its first cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= key_state_d & ~key_state_q;
      release_q <= ~key_state_d & key_state_q;
    end
  end

  assign key_press_o   = press_q;
  assign key_release_o = release_q;
`else
  assign key_press_o   = 1'b0;
  assign key_release_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - NKEYS independent pushbutton debouncers (events via KEY_DEBOUNCE_EVENTS_EN)
module key_debounce
  import key_pkg::*;
#(
  parameter int NKEYS           = KEY_NKEYS,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = KEY_SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n_raw,
  output logic [NKEYS-1:0] key_state,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release
);

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .key_n_raw_i  (key_n_raw[g]),
      .key_state_o  (key_state[g]),
      .key_press_o  (key_press[g]),
      .key_release_o(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed bench for key_debounce (DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
module tb_key_debounce;

`ifdef KEY_DEBOUNCE_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n_raw;
  logic [3:0] key_state, key_press, key_release;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NKEYS(4),
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n_raw  (key_n_raw),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] ev(input logic [3:0] v);
    return EV ? v : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] pr, input logic [3:0] rl);
    chk({tag, ".state"},   key_state,   st);
    chk({tag, ".press"},   key_press,   pr);
    chk({tag, ".release"}, key_release, rl);
  endtask

  initial begin
    reset     = 1'b1;
    key_n_raw = 4'b1111;
    tick(3);
    chk_all("in_reset", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk_all("idle", 4'b0000, 4'b0000, 4'b0000);
    end

    // key 0 press then release
    key_n_raw = 4'b1110;
    tick(9);
    chk_all("k0_press_pre", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("k0_press_edge", 4'b0001, ev(4'b0001), 4'b0000);
    tick(1);
    chk_all("k0_press_post", 4'b0001, 4'b0000, 4'b0000);
    key_n_raw = 4'b1111;
    tick(9);
    chk_all("k0_rel_pre", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    chk_all("k0_rel_edge", 4'b0000, 4'b0000, ev(4'b0001));
    tick(1);
    chk_all("k0_rel_post", 4'b0000, 4'b0000, 4'b0000);

    // key 1 bounce: runs of 3 never reach 8
    for (int i = 0; i < 40; i++) begin
      key_n_raw[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      chk_all("k1_bounce", 4'b0000, 4'b0000, 4'b0000);
    end
    key_n_raw = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_all("k1_settle", 4'b0000, 4'b0000, 4'b0000);
    end

    // key 2 held 30 cycles then released
    key_n_raw = 4'b1011;
    tick(30);
    chk_all("k2_held", 4'b0100, 4'b0000, 4'b0000);
    key_n_raw = 4'b1111;
    tick(9);
    chk_all("k2_rel_pre", 4'b0100, 4'b0000, 4'b0000);
    tick(1);
    chk_all("k2_rel_edge", 4'b0000, 4'b0000, ev(4'b0100));
    tick(1);
    chk_all("k2_rel_post", 4'b0000, 4'b0000, 4'b0000);

    // all keys on the same edge
    key_n_raw = 4'b0000;
    tick(9);
    chk_all("all_pre", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("all_edge", 4'b1111, ev(4'b1111), 4'b0000);
    tick(1);
    chk_all("all_post", 4'b1111, 4'b0000, 4'b0000);

    // key 3 into PEND_UP, then asynchronous reset
    key_n_raw = 4'b1000;
    tick(5);
    chk_all("k3_pend_up", 4'b1111, 4'b0000, 4'b0000);
    reset     = 1'b1;
    key_n_raw = 4'b0111;
    #1;
    chk_all("k3_async_rst", 4'b0000, 4'b0000, 4'b0000);
    tick(3);
    chk_all("k3_rst_hold", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    tick(9);
    chk_all("k3_re_pre", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("k3_re_edge", 4'b1000, ev(4'b1000), 4'b0000);
    tick(1);
    chk_all("k3_re_post", 4'b1000, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
